// File: rtl/sigma_deadtime_driver.sv
// sigma_deadtime_driver: turns the hybrid control law's raw switching variable
// into a complementary half-bridge gate pair with dead time on every
// commutation and a minimum on-time against chattering near the jump set.
// The committed sigma is returned as feedback and commutations are counted.
module sigma_deadtime_driver #(
  parameter int DT_CYCLES = 10,
  parameter int MIN_ON    = 50,
  parameter int CNT_W     = 16
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_sigma,
  input  logic             i_enable,
  output logic             o_gate_H,
  output logic             o_gate_L,
  output logic             o_sigma_fb,
  output logic [CNT_W-1:0] o_switch_count
);

  typedef enum logic [1:0] {IDLE, DT, ON_H, ON_L} state_t;

  localparam logic [7:0]       DT_LAST  = 8'(DT_CYCLES - 1);
  localparam logic [15:0]      MIN_ON_V = 16'(MIN_ON);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Dwell counter only needs to know that MIN_ON has been reached, so it
  // stops there instead of wrapping back below the threshold.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v < MIN_ON_V) ? v + 16'd1 : MIN_ON_V;
  endfunction

  logic       sigma_p0, sigma_p1;
  logic       sigma_s;
  state_t     state, state_n;
  logic       target, target_n;
  logic [7:0] dt_cnt, dt_cnt_n;
  logic [15:0] dwell, dwell_n;
  logic       fb_n;
  logic [CNT_W-1:0] cnt_n;

  assign sigma_s = sigma_p1;

  // Two-flop synchronizer for the asynchronous, possibly glitchy sigma request
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      sigma_p0 <= 1'b0;
      sigma_p1 <= 1'b0;
    end else begin
      sigma_p0 <= i_sigma;
      sigma_p1 <= sigma_p0;
    end
  end

  // Next-state logic: enable overrides everything, then dead time / dwell rules
  always_comb begin
    state_n  = state;
    target_n = target;
    dt_cnt_n = dt_cnt;
    dwell_n  = dwell;
    fb_n     = o_sigma_fb;
    cnt_n    = o_switch_count;
    if (!i_enable) begin
      state_n  = IDLE;
      dt_cnt_n = '0;
      dwell_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n  = DT;
          target_n = sigma_s;
          fb_n     = sigma_s;
          dt_cnt_n = '0;
        end
        DT: begin
          dt_cnt_n = dt_cnt + 8'd1;
          // A late change of mind retargets the commutation without
          // restarting the dead time already spent.
          if (sigma_s != target) begin
            target_n = sigma_s;
            fb_n     = sigma_s;
          end
          if (dt_cnt == DT_LAST) begin
            state_n = target_n ? ON_H : ON_L;
            dwell_n = '0;
            cnt_n   = o_switch_count + CNT_ONE;
          end
        end
        ON_H: begin
          dwell_n = sat_inc(dwell);
          if (!sigma_s && (dwell >= MIN_ON_V)) begin
            state_n  = DT;
            target_n = 1'b0;
            fb_n     = 1'b0;
            dt_cnt_n = '0;
          end
        end
        ON_L: begin
          dwell_n = sat_inc(dwell);
          if (sigma_s && (dwell >= MIN_ON_V)) begin
            state_n  = DT;
            target_n = 1'b1;
            fb_n     = 1'b1;
            dt_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and registered outputs, gates decoded from the next state
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      state          <= IDLE;
      target         <= 1'b0;
      dt_cnt         <= '0;
      dwell          <= '0;
      o_gate_H       <= 1'b0;
      o_gate_L       <= 1'b0;
      o_sigma_fb     <= 1'b0;
      o_switch_count <= '0;
    end else begin
      state          <= state_n;
      target         <= target_n;
      dt_cnt         <= dt_cnt_n;
      dwell          <= dwell_n;
      o_gate_H       <= (state_n == ON_H);
      o_gate_L       <= (state_n == ON_L);
      o_sigma_fb     <= fb_n;
      o_switch_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_sigma_deadtime_driver.sv
// Testbench for sigma_deadtime_driver: directed timing scenarios followed by
// randomized sigma/enable/reset traffic checked against a timestamp model.
module tb_sigma_deadtime_driver;

  localparam int DT_CYCLES = 10;
  localparam int MIN_ON    = 50;
  localparam int CNT_W     = 16;

  logic             i_CLK = 1'b0;
  logic             i_RESET = 1'b0;
  logic             i_sigma = 1'b0;
  logic             i_enable = 1'b0;
  logic             o_gate_H, o_gate_L, o_sigma_fb;
  logic [CNT_W-1:0] o_switch_count;

  int n_vec = 0;
  int n_err = 0;

  sigma_deadtime_driver #(
    .DT_CYCLES(DT_CYCLES),
    .MIN_ON   (MIN_ON),
    .CNT_W    (CNT_W)
  ) dut (
    .i_CLK         (i_CLK),
    .i_RESET       (i_RESET),
    .i_sigma       (i_sigma),
    .i_enable      (i_enable),
    .o_gate_H      (o_gate_H),
    .o_gate_L      (o_gate_L),
    .o_sigma_fb    (o_sigma_fb),
    .o_switch_count(o_switch_count)
  );

  always #5 i_CLK = ~i_CLK;

  // Reference model: phases with the edge number at which each phase began.
  // Dead time ends DT_CYCLES edges after it starts; a gate may be released
  // once more than MIN_ON edges have passed since it turned on. The sigma
  // seen by the law is the input as sampled two edges earlier.
  typedef enum {M_IDLE, M_DEAD, M_HIGH, M_LOW} mphase_t;
  mphase_t          m_phase = M_IDLE;
  int unsigned      cyc = 0;
  int unsigned      m_mark = 0;
  logic             m_H = 1'b0, m_L = 1'b0, m_fb = 1'b0, m_s = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_dly[$] = '{1'b0, 1'b0};

  always @(posedge i_CLK) begin
    cyc = cyc + 1;
    if (!i_RESET) begin
      m_phase = M_IDLE;
      m_fb    = 1'b0;
      m_cnt   = '0;
      m_dly   = '{1'b0, 1'b0};
    end else begin
      m_s = m_dly[0];
      void'(m_dly.pop_front());
      m_dly.push_back(i_sigma);
      if (!i_enable) begin
        m_phase = M_IDLE;
      end else begin
        case (m_phase)
          M_IDLE: begin
            m_phase = M_DEAD;
            m_mark  = cyc;
            m_fb    = m_s;
          end
          M_DEAD: begin
            m_fb = m_s;
            if (cyc - m_mark == DT_CYCLES) begin
              m_phase = m_s ? M_HIGH : M_LOW;
              m_mark  = cyc;
              m_cnt   = m_cnt + 1'b1;
            end
          end
          default: begin
            if ((m_s != (m_phase == M_HIGH)) && (cyc - m_mark > MIN_ON)) begin
              m_phase = M_DEAD;
              m_mark  = cyc;
              m_fb    = m_s;
            end
          end
        endcase
      end
    end
    m_H = (m_phase == M_HIGH);
    m_L = (m_phase == M_LOW);
  end

  // Gates must never both be on
  always @(negedge i_CLK) begin
    if (o_gate_H === 1'b1 && o_gate_L === 1'b1) begin
      n_err++;
      $display("FAIL shoot_through t=%0t: gate_H=%b gate_L=%b, required not both 1",
               $time, o_gate_H, o_gate_L);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_CLK);
  endtask

  task automatic test_reset;
    i_RESET = 1'b0; i_enable = 1'b0; i_sigma = 1'b0;
    tick(3);
    n_vec++;
    if ({o_gate_H, o_gate_L, o_sigma_fb} !== 3'b000) begin
      n_err++; $display("FAIL reset_outputs: got HLfb=%b%b%b want 000", o_gate_H, o_gate_L, o_sigma_fb);
    end
    n_vec++;
    if (o_switch_count !== '0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", o_switch_count);
    end
    i_RESET = 1'b1;
  endtask

  task automatic test_startup;
    i_sigma = 1'b1;
    tick(3);
    i_enable = 1'b1;
    tick(1);
    n_vec++;
    if (o_sigma_fb !== 1'b1 || o_gate_H !== 1'b0) begin
      n_err++; $display("FAIL startup_fb: got fb=%b H=%b want fb=1 H=0", o_sigma_fb, o_gate_H);
    end
    for (int k = 1; k <= DT_CYCLES; k++) begin
      tick(1);
      n_vec++;
      if (o_gate_H !== (k == DT_CYCLES) || o_gate_L !== 1'b0) begin
        n_err++; $display("FAIL startup_gate k=%0d: got H=%b L=%b want H=%b L=0",
                          k, o_gate_H, o_gate_L, (k == DT_CYCLES));
      end
    end
    n_vec++;
    if (o_switch_count !== 16'd1) begin
      n_err++; $display("FAIL startup_count: got %0d want 1", o_switch_count);
    end
  endtask

  task automatic test_commutation;
    tick(60);
    i_sigma = 1'b0;
    tick(2);
    n_vec++;
    if (o_gate_H !== 1'b1) begin
      n_err++; $display("FAIL commut_hold: got H=%b want 1", o_gate_H);
    end
    tick(1);
    n_vec++;
    if (o_gate_H !== 1'b0 || o_gate_L !== 1'b0) begin
      n_err++; $display("FAIL commut_off: got H=%b L=%b want 00", o_gate_H, o_gate_L);
    end
    for (int k = 1; k <= DT_CYCLES; k++) begin
      tick(1);
      n_vec++;
      if (o_gate_L !== (k == DT_CYCLES) || o_gate_H !== 1'b0) begin
        n_err++; $display("FAIL commut_dead k=%0d: got H=%b L=%b want H=0 L=%b",
                          k, o_gate_H, o_gate_L, (k == DT_CYCLES));
      end
    end
    n_vec++;
    if (o_switch_count !== 16'd2) begin
      n_err++; $display("FAIL commut_count: got %0d want 2", o_switch_count);
    end
  endtask

  task automatic test_min_on_hold;
    tick(2);
    i_sigma = 1'b1;
    tick(48);
    n_vec++;
    if (o_gate_L !== 1'b1) begin
      n_err++; $display("FAIL minon_held: got L=%b want 1", o_gate_L);
    end
    tick(1);
    n_vec++;
    if (o_gate_L !== 1'b0 || o_sigma_fb !== 1'b1) begin
      n_err++; $display("FAIL minon_release: got L=%b fb=%b want L=0 fb=1", o_gate_L, o_sigma_fb);
    end
    tick(DT_CYCLES - 1);
    n_vec++;
    if (o_gate_H !== 1'b0) begin
      n_err++; $display("FAIL minon_dead: got H=%b want 0", o_gate_H);
    end
    tick(1);
    n_vec++;
    if (o_gate_H !== 1'b1 || o_switch_count !== 16'd3) begin
      n_err++; $display("FAIL minon_on: got H=%b cnt=%0d want H=1 cnt=3", o_gate_H, o_switch_count);
    end
  endtask

  task automatic test_short_pulse;
    tick(2);
    i_sigma = 1'b0;
    tick(4);
    i_sigma = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(10);
      n_vec++;
      if (o_gate_H !== 1'b1 || o_switch_count !== 16'd3) begin
        n_err++; $display("FAIL pulse_ignored k=%0d: got H=%b cnt=%0d want H=1 cnt=3",
                          k, o_gate_H, o_switch_count);
      end
    end
  endtask

  task automatic test_dt_flip;
    i_enable = 1'b0;
    tick(1);
    n_vec++;
    if (o_gate_H !== 1'b0 || o_gate_L !== 1'b0) begin
      n_err++; $display("FAIL flip_disable: got H=%b L=%b want 00", o_gate_H, o_gate_L);
    end
    i_enable = 1'b1;
    tick(1);
    n_vec++;
    if (o_sigma_fb !== 1'b1) begin
      n_err++; $display("FAIL flip_fb_start: got %b want 1", o_sigma_fb);
    end
    tick(2);
    i_sigma = 1'b0;
    tick(2);
    n_vec++;
    if (o_sigma_fb !== 1'b1) begin
      n_err++; $display("FAIL flip_fb_early: got %b want 1", o_sigma_fb);
    end
    tick(1);
    n_vec++;
    if (o_sigma_fb !== 1'b0) begin
      n_err++; $display("FAIL flip_fb_follow: got %b want 0", o_sigma_fb);
    end
    tick(4);
    n_vec++;
    if (o_gate_H !== 1'b0 || o_gate_L !== 1'b0) begin
      n_err++; $display("FAIL flip_dead: got H=%b L=%b want 00", o_gate_H, o_gate_L);
    end
    tick(1);
    n_vec++;
    if (o_gate_L !== 1'b1 || o_gate_H !== 1'b0 || o_switch_count !== 16'd4) begin
      n_err++; $display("FAIL flip_on: got H=%b L=%b cnt=%0d want H=0 L=1 cnt=4",
                        o_gate_H, o_gate_L, o_switch_count);
    end
  endtask

  task automatic test_enable_drop;
    tick(5);
    i_enable = 1'b0;
    tick(1);
    n_vec++;
    if (o_gate_H !== 1'b0 || o_gate_L !== 1'b0 || o_switch_count !== 16'd4) begin
      n_err++; $display("FAIL enable_drop: got H=%b L=%b cnt=%0d want 00 cnt=4",
                        o_gate_H, o_gate_L, o_switch_count);
    end
  endtask

  task automatic test_reset_mid_dt;
    i_enable = 1'b1;
    i_sigma  = 1'b1;
    tick(4);
    n_vec++;
    if (o_sigma_fb !== 1'b1) begin
      n_err++; $display("FAIL middt_fb: got %b want 1", o_sigma_fb);
    end
    i_RESET = 1'b0;
    tick(1);
    n_vec++;
    if ({o_gate_H, o_gate_L, o_sigma_fb} !== 3'b000 || o_switch_count !== '0) begin
      n_err++; $display("FAIL middt_reset: got HLfb=%b%b%b cnt=%0d want 000 cnt=0",
                        o_gate_H, o_gate_L, o_sigma_fb, o_switch_count);
    end
    i_RESET = 1'b1;
  endtask

  task automatic test_random;
    int hold, en_off, rst_off;
    hold = 1; en_off = 0; rst_off = 0;
    i_enable = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      tick(1);
      n_vec++;
      if (o_gate_H !== m_H || o_gate_L !== m_L) begin
        n_err++; $display("FAIL rand_gates k=%0d: got H=%b L=%b want H=%b L=%b",
                          k, o_gate_H, o_gate_L, m_H, m_L);
      end
      n_vec++;
      if (o_sigma_fb !== m_fb) begin
        n_err++; $display("FAIL rand_fb k=%0d: got %b want %b", k, o_sigma_fb, m_fb);
      end
      n_vec++;
      if (o_switch_count !== m_cnt) begin
        n_err++; $display("FAIL rand_count k=%0d: got %0d want %0d", k, o_switch_count, m_cnt);
      end
      hold--;
      if (hold <= 0) begin
        i_sigma = ~i_sigma;
        hold = $urandom_range(1, 120);
      end
      if (en_off > 0) begin
        en_off--;
        if (en_off == 0) i_enable = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        i_enable = 1'b0;
        en_off = $urandom_range(1, 20);
      end
      if (rst_off > 0) begin
        rst_off--;
        if (rst_off == 0) i_RESET = 1'b1;
      end else if ($urandom_range(0, 1499) == 0) begin
        i_RESET = 1'b0;
        rst_off = $urandom_range(1, 3);
      end
    end
    i_RESET = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_commutation();
    test_min_on_hold();
    test_short_pulse();
    test_dt_flip();
    test_enable_drop();
    test_reset_mid_dt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sigma_deadtime_driver.md
Name: sigma_deadtime_driver

Overview:
- Downstream stage of the hybrid switching-law block.
- Takes the raw switching variable sigma and drives the complementary half-bridge gate pair.
- Inserts dead time on every commutation and enforces a minimum on-time to suppress chattering near the jump set.
- Returns the committed sigma as the feedback input of the hybrid control law, and counts commutations for debug.

Parameters:
- DT_CYCLES, 10, dead time in clock cycles with both gates off; legal range is 1 to 255.
- MIN_ON, 50, minimum cycles a gate stays on before a new commutation is accepted; legal range is 1 to 65535.
- CNT_W, 16, width of the commutation counter.

Ports:
- i_CLK  input  1  system clock.
- i_RESET  input  1  synchronous reset, active-low.
- i_sigma  input  1  raw switching request from the hybrid control law; asynchronous to i_CLK's logic and possibly glitchy.
- i_enable  input  1  power-stage enable; low forces both gates off.
- o_gate_H  output  1  high-side gate command.
- o_gate_L  output  1  low-side gate command.
- o_sigma_fb  output  1  committed switching state; feeds the sigma feedback input of the hybrid control law.
- o_switch_count  output  CNT_W  number of completed commutations.

Behaviour:
- Clock and reset:
  - One clock, i_CLK.
  - i_RESET is synchronous and active-low: it is sampled on the rising edge of i_CLK and has priority over everything else.
- Reset values:
  - state = IDLE.
  - o_gate_H = 0, o_gate_L = 0, o_sigma_fb = 0.
  - o_switch_count = 0.
  - Both synchronizer flops = 0.
  - Dead-time and dwell counters = 0.
- Synchronizer:
  - i_sigma passes through a 2-flop synchronizer; sigma_s is the output of the second flop.
  - i_enable is used directly; it is a register-level control.
- Outputs:
  - All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
  - o_gate_H and o_gate_L are never both 1; the verification bench asserts this every cycle.
- State machine, with states IDLE, DT, ON_H and ON_L:
  - i_enable = 0 in any state: next state is IDLE, both gates go 0 on that edge, and dwell and dead-time counters clear. Enable outranks every other transition.
  - IDLE, gates 00: when i_enable = 1, go to DT. Set target = sigma_s and o_sigma_fb = sigma_s. Clear dt_cnt.
  - DT, gates 00:
    - dt_cnt increments each cycle.
    - If sigma_s differs from target, re-latch target and o_sigma_fb; dt_cnt is not restarted.
    - When dt_cnt = DT_CYCLES-1, go to ON_H if target = 1, else ON_L. Clear dwell_cnt and increment o_switch_count, which wraps modulo 2^CNT_W.
  - ON_H, gates 10:
    - dwell_cnt increments and saturates at MIN_ON.
    - If sigma_s = 0 and dwell_cnt >= MIN_ON, go to DT with target = 0 and o_sigma_fb = 0, and clear dt_cnt.
    - A request arriving before MIN_ON is satisfied is held, not dropped. It is acted on as soon as the dwell condition is met, provided it is still present then.
  - ON_L, gates 01: mirror of ON_H; leaves to DT when sigma_s = 1 and dwell_cnt >= MIN_ON.
- Latency:
  - i_sigma edge to sigma_s: 2 cycles.
  - sigma_s change (dwell satisfied) to active gate off: 1 cycle.
  - Active gate off to opposite gate on: exactly DT_CYCLES cycles.
  - The first gate after enable turns on DT_CYCLES cycles after leaving IDLE.
- Pulses shorter than 1 cycle on i_sigma may be missed; this is acceptable.
- Reset asserted mid-dead-time or mid-dwell: outputs return to reset values on that edge, with no partial dead time carried over.

Test Plan:
- Reset then i_enable = 1 with i_sigma = 1 held (DT_CYCLES = 10, MIN_ON = 50) -> o_sigma_fb = 1 one cycle after enable is sampled; o_gate_H rises 10 cycles after entering DT; o_switch_count = 1.
- In ON_H after 60 cycles, drop i_sigma to 0 -> o_gate_H falls 3 cycles later; o_gate_L rises exactly 10 cycles after that; o_switch_count = 2; both gates are never high together.
- In ON_H, toggle i_sigma to 0 at dwell 5 and hold -> o_gate_H stays high until dwell reaches 50, then falls on the following edge.
- In ON_H, pulse i_sigma to 0 for 4 cycles at dwell 5 -> no commutation; o_switch_count unchanged.
- During DT toward ON_H, flip i_sigma to 0 -> o_sigma_fb follows after 2-3 cycles; the dead-time end is unchanged; o_gate_L turns on instead of o_gate_H.
- In ON_L: deassert i_enable -> both gates 0 on the next edge. Separately, assert i_RESET = 0 mid-DT -> all outputs and o_switch_count read 0 on the next edge.
